// File: rtl/msrh_freelist_alloc_ctrl.sv
// Shares one single-pop/single-push ID freelist among several allocators and release sources:
// round-robin pop arbitration, a compacting release queue, and occupancy tracking.
module msrh_freelist_alloc_ctrl #(
  parameter int SIZE     = 32,
  parameter int WIDTH    = 5,
  parameter int REQ_NUM  = 2,
  parameter int REL_NUM  = 2,
  parameter int RQ_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [REQ_NUM-1:0]         i_req_valid,
  output logic [REQ_NUM-1:0]         o_req_grant,
  output logic [WIDTH-1:0]           o_req_id,
  input  logic [REL_NUM-1:0]         i_rel_valid,
  input  logic [REL_NUM*WIDTH-1:0]   i_rel_id,
  output logic                       o_rel_ready,
  input  logic                       i_flush,
  output logic                       o_fl_pop,
  input  logic [WIDTH-1:0]           i_fl_pop_id,
  output logic                       o_fl_push,
  output logic [WIDTH-1:0]           o_fl_push_id,
  output logic [$clog2(SIZE+1)-1:0]  o_free_cnt,
  output logic                       o_overflow
);
  localparam int CNT_W = $clog2(SIZE + 1);
  localparam int PTR_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int QC_W  = PTR_W + 1;
  localparam int RR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CNT_W-1:0] FREE_FULL = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [QC_W-1:0]  Q_ONE     = QC_W'(1);
  localparam logic [QC_W-1:0]  Q_DEPTH   = QC_W'(RQ_DEPTH);
  localparam logic [QC_W-1:0]  Q_BURST   = QC_W'(REL_NUM);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  function automatic logic [RR_W-1:0] rr_wrap(input logic [RR_W-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= REQ_NUM) sum = sum - REQ_NUM;
    return RR_W'(sum);
  endfunction

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] free_cnt, free_cnt_nxt;
  logic [RR_W-1:0]  rr_ptr, cand, grant_idx;
  logic             grant_hit, grant_fire;
  logic             overflow;
  logic [WIDTH-1:0] rq_mem [RQ_DEPTH];
  logic [PTR_W-1:0] rq_head, rq_tail;
  logic [QC_W-1:0]  rq_cnt, rq_cnt_nxt, enq_num;
  logic [PTR_W-1:0] enq_ofs [REL_NUM];
  logic             deq, ovf_hit;

  // First valid requester at or after rr_ptr
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = rr_wrap(rr_ptr, i);
      if (!grant_hit && i_req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Uses the registered count, so an ID pushed this cycle is only poppable next cycle
  assign grant_fire = grant_hit && (state == RUN) && !i_flush && (free_cnt != '0);

  always_comb begin
    o_req_grant = '0;
    if (grant_fire) o_req_grant[grant_idx] = 1'b1;
  end

  assign o_fl_pop = grant_fire;
  assign o_req_id = i_fl_pop_id;

  // Valid lanes are packed into consecutive slots in source order
  always_comb begin
    enq_num = '0;
    for (int k = 0; k < REL_NUM; k++) begin
      enq_ofs[k] = enq_num[PTR_W-1:0];
      if (i_rel_valid[k]) enq_num = enq_num + Q_ONE;
    end
  end

  assign o_rel_ready  = (state != INIT) && ((Q_DEPTH - rq_cnt) >= Q_BURST);
  assign deq          = (rq_cnt != '0) && (state != INIT);
  // A push into an already full freelist is dropped and flagged rather than corrupting the count
  assign ovf_hit      = deq && (free_cnt == FREE_FULL);
  assign o_fl_push    = deq && !ovf_hit;
  assign o_fl_push_id = rq_mem[rq_head];
  assign o_free_cnt   = free_cnt;
  assign o_overflow   = overflow;

  always_comb begin
    rq_cnt_nxt = rq_cnt;
    if (o_rel_ready) rq_cnt_nxt = rq_cnt_nxt + enq_num;
    if (deq)         rq_cnt_nxt = rq_cnt_nxt - Q_ONE;
  end

  always_comb begin
    free_cnt_nxt = free_cnt;
    if (o_fl_push && !o_fl_pop)      free_cnt_nxt = free_cnt + CNT_ONE;
    else if (!o_fl_push && o_fl_pop) free_cnt_nxt = free_cnt - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = RUN;
      RUN:     if (i_flush) state_nxt = HOLD;
      HOLD:    if (!i_flush && (rq_cnt_nxt == '0)) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= INIT;
      free_cnt <= FREE_FULL;
      rq_head  <= '0;
      rq_tail  <= '0;
      rq_cnt   <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      free_cnt <= free_cnt_nxt;
      rq_cnt   <= rq_cnt_nxt;
      if (deq)         rq_head <= rq_head + PTR_ONE;
      if (o_rel_ready) rq_tail <= rq_tail + enq_num[PTR_W-1:0];
      if (grant_fire)  rr_ptr  <= rr_wrap(grant_idx, 1);
      if (ovf_hit)     overflow <= 1'b1;
    end
  end

  // Queue storage carries no reset; the pointers alone define what is live
  always_ff @(posedge i_clk) begin
    if (o_rel_ready) begin
      for (int k = 0; k < REL_NUM; k++) begin
        if (i_rel_valid[k]) rq_mem[rq_tail + enq_ofs[k]] <= i_rel_id[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_msrh_freelist_alloc_ctrl.sv
// Bench for msrh_freelist_alloc_ctrl: directed scenarios plus random traffic, all compared
// every cycle against a queue-based behavioural model of the controller.
module tb_msrh_freelist_alloc_ctrl;
  localparam int SIZE     = 32;
  localparam int WIDTH    = 5;
  localparam int REQ_NUM  = 2;
  localparam int REL_NUM  = 2;
  localparam int RQ_DEPTH = 4;
  localparam int CNT_W    = $clog2(SIZE + 1);

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [REQ_NUM-1:0]       req = '0;
  logic [REL_NUM-1:0]       rel_v = '0;
  logic [REL_NUM*WIDTH-1:0] rel_id_bus = '0;
  logic                     flush = 1'b0;
  logic [WIDTH-1:0]         fl_pop_id = '0;
  logic [REQ_NUM-1:0]       grant;
  logic [WIDTH-1:0]         req_id;
  logic                     rel_ready, fl_pop, fl_push, overflow;
  logic [WIDTH-1:0]         fl_push_id;
  logic [CNT_W-1:0]         free_cnt;

  msrh_freelist_alloc_ctrl #(
    .SIZE(SIZE), .WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .REL_NUM(REL_NUM), .RQ_DEPTH(RQ_DEPTH)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req), .o_req_grant(grant), .o_req_id(req_id),
    .i_rel_valid(rel_v), .i_rel_id(rel_id_bus), .o_rel_ready(rel_ready), .i_flush(flush),
    .o_fl_pop(fl_pop), .i_fl_pop_id(fl_pop_id), .o_fl_push(fl_push), .o_fl_push_id(fl_push_id),
    .o_free_cnt(free_cnt), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int checks = 0;
  int miscompares = 0;

  int fl[$];           // freelist storage as seen by the environment
  int outstanding[$];  // IDs currently held by allocators
  int rel_ids[REL_NUM];
  int ids[4];

  // Behavioural model
  int m_q[$];
  int m_free, m_rr;
  bit m_init, m_hold, m_ovf;
  logic [REQ_NUM-1:0] e_grant;
  int e_gidx, e_push_id;
  bit e_ready, e_deq, e_push;

  logic cap_pop, cap_push;
  logic [WIDTH-1:0] cap_push_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return !m_init && ((RQ_DEPTH - m_q.size()) >= REL_NUM);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_free = SIZE; m_rr = 0;
    m_init = 1'b1; m_hold = 1'b0; m_ovf = 1'b0;
    fl.delete();
    for (int i = 0; i < SIZE; i++) fl.push_back(i);
    outstanding.delete();
  endtask

  task automatic model_eval();
    int c;
    e_ready   = m_ready();
    e_deq     = !m_init && (m_q.size() != 0);
    e_push    = e_deq && (m_free != SIZE);
    e_push_id = (m_q.size() != 0) ? m_q[0] : 0;
    e_gidx    = -1;
    if (!m_init && !m_hold && !flush && m_free > 0) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        c = (m_rr + i) % REQ_NUM;
        if (e_gidx < 0 && req[c]) e_gidx = c;
      end
    end
    e_grant = '0;
    if (e_gidx >= 0) e_grant[e_gidx] = 1'b1;
  endtask

  task automatic model_step();
    if (e_deq) begin
      void'(m_q.pop_front());
      if (!e_push) m_ovf = 1'b1;
    end
    if (e_ready)
      for (int k = 0; k < REL_NUM; k++) if (rel_v[k]) m_q.push_back(rel_ids[k]);
    if (e_push) m_free++;
    if (e_gidx >= 0) begin
      m_free--;
      m_rr = (e_gidx + 1) % REQ_NUM;
      outstanding.push_back(int'(fl_pop_id));
    end
    if (m_init) m_init = 1'b0;
    else if (!m_hold && flush) m_hold = 1'b1;
    else if (m_hold && !flush && m_q.size() == 0) m_hold = 1'b0;
  endtask

  task automatic settle();
    fl_pop_id = (fl.size() > 0) ? WIDTH'(fl[0]) : '0;
    for (int k = 0; k < REL_NUM; k++) rel_id_bus[k*WIDTH +: WIDTH] = WIDTH'(rel_ids[k]);
    #1;
    vectors++;
    model_eval();
    if (rel_v != '0) begin
      checks++;
      assert (rel_ready) else begin
        miscompares++;
        $display("FAIL rel_when_not_ready at %0t: ready %0d, required 1", $time, rel_ready);
      end
    end
    chk("grant", grant, e_grant);
    chk("pop", fl_pop, e_gidx >= 0);
    if (e_gidx >= 0) chk("req_id", req_id, fl_pop_id);
    chk("rel_ready", rel_ready, e_ready);
    chk("push", fl_push, e_push);
    if (e_push) chk("push_id", fl_push_id, e_push_id);
    chk("free_cnt", free_cnt, m_free);
    chk("overflow", overflow, m_ovf);
    cap_pop = fl_pop; cap_push = fl_push; cap_push_id = fl_push_id;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    if (cap_pop && fl.size() > 0) void'(fl.pop_front());
    if (cap_push) fl.push_back(int'(cap_push_id));
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; rel_v = '0; flush = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_free_cnt", free_cnt, SIZE);
    chk("rst_grant", grant, 0);
    chk("rst_pop", fl_pop, 0);
    chk("rst_push", fl_push, 0);
    chk("rst_rel_ready", rel_ready, 0);
    chk("rst_overflow", overflow, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic take_id(output int id);
    id = outstanding.pop_front();
  endtask

  task automatic drop_id(input int id);
    for (int i = 0; i < outstanding.size(); i++)
      if (outstanding[i] == id) begin
        outstanding.delete(i);
        break;
      end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Round-robin start-up
    req = 2'b11;
    settle(); chk("init_no_grant", grant, 0); chk("init_free_cnt", free_cnt, 32); advance();
    for (int j = 1; j <= 6; j++) begin
      settle();
      chk("rr_grant", grant, (j % 2 == 1) ? 1 : 2);
      chk("rr_id", req_id, j - 1);
      chk("rr_free_cnt", free_cnt, 33 - j);
      advance();
    end

    // Drain to empty, then recycle ID 7
    req = 2'b01;
    for (int n = 0; n < 64 && m_free > 0; n++) begin settle(); advance(); end
    if (m_free != 0) begin miscompares++; $display("FAIL drain_timeout: free %0d, required 0", m_free); end
    settle(); chk("empty_no_grant", grant, 0); chk("empty_free_cnt", free_cnt, 0); advance();
    drop_id(7);
    rel_v = 2'b01; rel_ids[0] = 7;
    settle(); chk("enq_cycle_no_grant", grant, 0); advance();
    rel_v = '0;
    settle();
    chk("push_cycle_push", fl_push, 1); chk("push_cycle_id", fl_push_id, 7);
    chk("push_cycle_no_grant", grant, 0);
    advance();
    settle(); chk("regrant", grant, 1); chk("regrant_id", req_id, 7); advance();

    // Two-cycle dual release burst, no allocation
    req = '0;
    for (int i = 0; i < 4; i++) take_id(ids[i]);
    rel_v = 2'b11; rel_ids[0] = ids[0]; rel_ids[1] = ids[1];
    settle(); chk("burst0_ready", rel_ready, 1); advance();
    rel_ids[0] = ids[2]; rel_ids[1] = ids[3];
    settle(); chk("burst1_ready", rel_ready, 1); chk("burst_push0", fl_push_id, ids[0]); advance();
    rel_v = '0;
    settle(); chk("ready_drop", rel_ready, 0); chk("burst_push1", fl_push_id, ids[1]); advance();
    settle(); chk("ready_back", rel_ready, 1); chk("burst_push2", fl_push_id, ids[2]); advance();
    settle(); chk("burst_push3_v", fl_push, 1); chk("burst_push3", fl_push_id, ids[3]); advance();
    settle(); chk("burst_done", fl_push, 0); advance();

    // Flush while three releases are queued
    req = 2'b11;
    rel_v = 2'b11; take_id(rel_ids[0]); take_id(rel_ids[1]);
    settle(); advance();
    take_id(rel_ids[0]); take_id(rel_ids[1]);
    settle(); advance();
    rel_v = '0; flush = 1'b1;
    settle(); chk("flush_no_grant", grant, 0); chk("flush_push", fl_push, 1); advance();
    flush = 1'b0;
    for (int n = 0; n < 2; n++) begin
      settle(); chk("hold_no_grant", grant, 0); chk("hold_push", fl_push, 1); advance();
    end
    settle(); chk("resume_grant", |grant, 1); chk("resume_no_push", fl_push, 0); advance();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req = REQ_NUM'($urandom_range(0, (1 << REQ_NUM) - 1));
      flush = ($urandom_range(0, 15) == 0);
      rel_v = '0;
      if (m_ready())
        for (int k = 0; k < REL_NUM; k++)
          if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
            int idx;
            idx = int'($urandom_range(0, outstanding.size() - 1));
            rel_ids[k] = outstanding[idx];
            outstanding.delete(idx);
            rel_v[k] = 1'b1;
          end
      settle(); advance();
    end

    // Reach free_cnt=10 with an empty queue, queue two releases, then reset
    flush = 1'b0;
    for (int n = 0; n < 200 && !(m_free == 10 && m_q.size() == 0 && !m_hold); n++) begin
      req = (m_free + m_q.size() > 10) ? 2'b01 : 2'b00;
      rel_v = '0;
      if (m_free + m_q.size() < 10 && m_ready() && outstanding.size() > 0) begin
        take_id(rel_ids[0]); rel_v = 2'b01;
      end
      settle(); advance();
    end
    if (!(m_free == 10 && m_q.size() == 0)) begin
      miscompares++; $display("FAIL setup_timeout: free %0d, required 10", m_free);
    end
    req = '0; rel_v = 2'b11; take_id(rel_ids[0]); take_id(rel_ids[1]);
    settle(); advance();
    rel_v = '0;
    #1;
    chk("pre_reset_free_cnt", free_cnt, 10);
    chk("pre_reset_queued", fl_push, 1);
    do_reset();
    req = 2'b11;
    settle(); chk("post_reset_init", grant, 0); chk("post_reset_no_push", fl_push, 0); advance();

    // Release into a full freelist
    req = '0; rel_v = 2'b01; rel_ids[0] = 3;
    settle(); chk("ovf_enq_ready", rel_ready, 1); advance();
    rel_v = '0;
    settle(); chk("ovf_push_suppressed", fl_push, 0); chk("ovf_free_cnt", free_cnt, 32); advance();
    for (int n = 0; n < 3; n++) begin
      settle(); chk("ovf_sticky", overflow, 1); chk("ovf_free_hold", free_cnt, 32); advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
